// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared types and result codes for the wide sequential comparator
package compare_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [1:0] EQ = 2'd0;
  localparam logic [1:0] GT = 2'd1;
  localparam logic [1:0] LT = 2'd2;

  // Chunk index width; a single-chunk operand still needs a 1-bit index.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/wide_compare_seq_if.sv
// rtl/wide_compare_seq_if.sv - operand/result handshake bundle for wide_compare_seq
interface wide_compare_seq_if #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
);
  localparam int IW = compare_pkg::idx_width(WIDTH / CHUNK);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             greater;
  logic             less;
  logic             meets;
  logic [IW:0]      cycles;

  modport master (
    output in_valid, a, b, flush, out_ready,
    input  in_ready, out_valid, equal, greater, less, meets, cycles
  );

  modport slave (
    input  in_valid, a, b, flush, out_ready,
    output in_ready, out_valid, equal, greater, less, meets, cycles
  );
endinterface

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one operand chunk
module chunk_cmp #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq,
  output logic             gt
);
  assign eq = (x == y);
  assign gt = (x > y);
endmodule

// File: rtl/wide_compare_seq.sv
// rtl/wide_compare_seq.sv - multi-cycle MSB-first unsigned comparator with early exit
module wide_compare_seq
  import compare_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input logic               clk,
  input logic               rst_n,
  wide_compare_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NCHUNK - 1);
  localparam logic [IW:0]   NCHUNK_W = (IW + 1)'(NCHUNK);

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             in_ready_q, out_valid_q;
  logic             equal_q, greater_q, less_q, meets_q;
  logic [IW:0]      cycles_q;

  // Shifting instead of an indexed part-select keeps the select legal when NCHUNK is 1.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c_eq, c_gt;

  assign a_sh = a_q >> (CHUNK * int'(idx));
  assign b_sh = b_q >> (CHUNK * int'(idx));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x  (a_sh[CHUNK-1:0]),
    .y  (b_sh[CHUNK-1:0]),
    .eq (c_eq),
    .gt (c_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      less_q      <= 1'b0;
      meets_q     <= 1'b0;
      cycles_q    <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      less_q      <= 1'b0;
      meets_q     <= 1'b0;
      cycles_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            idx        <= IDX_TOP;
            in_ready_q <= 1'b0;
            state      <= SCAN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (!c_eq) begin
            greater_q   <= c_gt;
            less_q      <= !c_gt;
            meets_q     <= !c_gt;
            cycles_q    <= NCHUNK_W - {1'b0, idx};
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            equal_q     <= 1'b1;
            meets_q     <= 1'b1;
            cycles_q    <= NCHUNK_W;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          // Ready comes back on the cycle after the result is taken, never the same one.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            less_q      <= 1'b0;
            meets_q     <= 1'b0;
            cycles_q    <= '0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.equal     = equal_q;
  assign bus.greater   = greater_q;
  assign bus.less      = less_q;
  assign bus.meets     = meets_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_wide_compare_seq.sv
// tb/tb_wide_compare_seq.sv - directed and random checks of wide_compare_seq
module tb_wide_compare_seq;
  import compare_pkg::*;

  logic clk;
  logic rst_n;

  wide_compare_seq_if #(.WIDTH(32), .CHUNK(8)) bus ();
  wide_compare_seq_if #(.WIDTH(8),  .CHUNK(8)) bus8 ();

  wide_compare_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wide_compare_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  code;
    int          cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready32;
    int t;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_valid32(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result32(input string tag, input logic [1:0] code, input int cyc);
    chk({tag, "_valid"},   32'(bus.out_valid), 32'd1);
    chk({tag, "_equal"},   32'(bus.equal),     32'(code == EQ));
    chk({tag, "_greater"}, 32'(bus.greater),   32'(code == GT));
    chk({tag, "_less"},    32'(bus.less),      32'(code == LT));
    chk({tag, "_meets"},   32'(bus.meets),     32'(code != GT));
    chk({tag, "_cycles"},  32'(bus.cycles),    32'(cyc));
  endtask

  task automatic check_cleared32(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_results"},
        32'({bus.equal, bus.greater, bus.less, bus.meets, bus.cycles}), 32'd0);
  endtask

  task automatic run_pair32(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] code, input int cyc);
    int lat;
    wait_ready32();
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid32(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(cyc));
    check_result32(tag, code, cyc);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_cleared32({tag, "_after_take"});
    chk({tag, "_in_ready_next"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int t;
    logic [7:0] ra, rb;
    logic [1:0] rcode;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{32'h0000_0064, 32'h0000_0064, EQ, 4};
    vecs[1] = '{32'hFF00_0000, 32'h0000_0000, GT, 1};
    vecs[2] = '{32'h1234_5633, 32'h1234_567A, LT, 4};
    vecs[3] = '{32'h0001_0000, 32'h0002_0000, LT, 2};
    vecs[4] = '{32'h0000_FF00, 32'h0000_FE00, GT, 3};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, EQ, 4};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, LT, 4};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, GT, 1};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.flush     = 1'b0;
    bus8.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_cleared32("rst");
    rst_n = 1'b1;
    chk("rel_in_ready_before_clk", 32'(bus.in_ready), 32'd0);
    tick();
    chk("rel_in_ready_first_clk", 32'(bus.in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_pair32($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].cyc);
    end

    // Hold result under back-pressure; operand changes after accept are ignored
    wait_ready32();
    bus.a        = 32'h1234_5633;
    bus.b        = 32'h1234_567A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 32'hFFFF_FFFF;
    bus.b        = 32'h0000_0000;
    wait_valid32(lat);
    chk("hold_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check_result32($sformatf("hold%0d", i), LT, 4);
      chk($sformatf("hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_cleared32("hold_take");

    // Flush in the second SCAN cycle
    wait_ready32();
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_scan_in_ready", 32'(bus.in_ready), 32'd1);
    t = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) t++;
      tick();
    end
    chk("flush_scan_no_valid", 32'(t), 32'd0);
    run_pair32("post_flush", 32'd5, 32'd3, GT, 4);

    // Flush together with in_valid in IDLE: pair is dropped
    wait_ready32();
    bus.a        = 32'd7;
    bus.b        = 32'd7;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);
    t = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) t++;
      tick();
    end
    chk("flush_idle_no_accept", 32'(t), 32'd0);

    // Flush in DONE beats out_ready
    wait_ready32();
    bus.a        = 32'h0100_0000;
    bus.b        = 32'h0200_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid32(lat);
    check_result32("pre_flush_done", LT, 1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check_cleared32("flush_done");
    chk("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset while DONE
    wait_ready32();
    bus.a        = 32'hFF00_0000;
    bus.b        = 32'h0000_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rst_done_valid_before", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared32("rst_done_async");
    chk("rst_done_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_done_rel_before_clk", 32'(bus.in_ready), 32'd0);
    tick();
    chk("rst_done_rel_first_clk", 32'(bus.in_ready), 32'd1);
    run_pair32("post_rst", 32'h0000_00FF, 32'h0000_00FF, EQ, 4);

    // Single-chunk instance: random pairs with random consumer stalls
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 16 == 0) rb = ra;
      rcode = (ra == rb) ? EQ : ((ra > rb) ? GT : LT);
      t = 0;
      while (!bus8.in_ready && t < 20) begin
        tick();
        t++;
      end
      if (!bus8.in_ready) begin
        chk("rnd_in_ready_timeout", 32'(bus8.in_ready), 32'd1);
      end
      bus8.a        = ra;
      bus8.b        = rb;
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd1);
      t = $urandom_range(0, 3);
      for (int s = 0; s < t; s++) tick();
      chk($sformatf("rnd%0d_result a=%0h b=%0h", i, ra, rb),
          32'({bus8.out_valid, bus8.equal, bus8.greater, bus8.less, bus8.meets, bus8.cycles}),
          32'({1'b1, rcode == EQ, rcode == GT, rcode == LT, rcode != GT, 2'd1}));
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
